// File: rtl/trace_checker.sv
// Write-back trace checker: compares each architectural register write
// reported on the core's debug port against a golden-trace FIFO. It counts
// matches, latches the first error, and reports done/pass/fail once the
// core reaches END_PC.
module trace_checker #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] END_PC     = 32'h1c000100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] debug_wb_pc,
  input  logic [3:0]  debug_wb_rf_we,
  input  logic [4:0]  debug_wb_rf_wnum,
  input  logic [31:0] debug_wb_rf_wdata,
  input  logic        gold_valid,
  output logic        gold_ready,
  input  logic [31:0] gold_pc,
  input  logic [4:0]  gold_wnum,
  input  logic [31:0] gold_wdata,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [1:0]  err_code,
  output logic [31:0] err_pc,
  output logic [31:0] err_exp_wdata,
  output logic [31:0] err_got_wdata,
  output logic [31:0] match_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {S_RUN, S_DONE, S_FAIL} state_t;

  state_t state;

  // Golden entry storage; contents need no reset because the pointers
  // decide what is valid.
  logic [31:0] mem_pc    [FIFO_DEPTH];
  logic [4:0]  mem_wnum  [FIFO_DEPTH];
  logic [31:0] mem_wdata [FIFO_DEPTH];

  // One extra pointer bit distinguishes full from empty.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic        wr_event;
  logic        hit;
  logic [31:0] head_pc;
  logic [4:0]  head_wnum;
  logic [31:0] head_wdata;

  // Only bytes the core actually writes take part in the data compare.
  function automatic logic bytes_equal(input logic [3:0]  we,
                                       input logic [31:0] got,
                                       input logic [31:0] exp);
    logic eq;
    eq = 1'b1;
    for (int b = 0; b < 4; b++) begin
      if (we[b] && (got[8*b +: 8] != exp[8*b +: 8])) eq = 1'b0;
    end
    return eq;
  endfunction

  // Occupancy, handshake and compare decode.
  always_comb begin
    empty      = (wr_ptr == rd_ptr);
    full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    gold_ready = ~full;
    push       = gold_valid & ~full;
    wr_event   = (debug_wb_rf_we != 4'd0) && (debug_wb_rf_wnum != 5'd0);
    pop        = (state == S_RUN) && wr_event && !empty;
    head_pc    = mem_pc[rd_ptr[AW-1:0]];
    head_wnum  = mem_wnum[rd_ptr[AW-1:0]];
    head_wdata = mem_wdata[rd_ptr[AW-1:0]];
    hit        = (debug_wb_pc == head_pc) && (debug_wb_rf_wnum == head_wnum) &&
                 bytes_equal(debug_wb_rf_we, debug_wb_rf_wdata, head_wdata);
  end

  // Write accepted golden entries into storage.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr[AW-1:0]]    <= gold_pc;
      mem_wnum[wr_ptr[AW-1:0]]  <= gold_wnum;
      mem_wdata[wr_ptr[AW-1:0]] <= gold_wdata;
    end
  end

  // Advance FIFO pointers; push and pop may happen in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Checker FSM: checks events in RUN, latches first error, stops at END_PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_RUN;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      err_code      <= 2'd0;
      err_pc        <= '0;
      err_exp_wdata <= '0;
      err_got_wdata <= '0;
      match_cnt     <= '0;
    end else if (state == S_RUN) begin
      if (wr_event && empty) begin
        state         <= S_FAIL;
        done          <= 1'b1;
        fail          <= 1'b1;
        err_code      <= 2'd2;
        err_pc        <= debug_wb_pc;
        err_exp_wdata <= '0;
        err_got_wdata <= debug_wb_rf_wdata;
      end else if (wr_event && !hit) begin
        state         <= S_FAIL;
        done          <= 1'b1;
        fail          <= 1'b1;
        err_code      <= 2'd1;
        err_pc        <= debug_wb_pc;
        err_exp_wdata <= head_wdata;
        err_got_wdata <= debug_wb_rf_wdata;
      end else begin
        if (wr_event) match_cnt <= match_cnt + 32'd1;
        if (debug_wb_pc == END_PC) begin
          state <= S_DONE;
          done  <= 1'b1;
          pass  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/trace_checker.md
# trace_checker

Write-back trace checker for the single-cycle LoongArch core's debug interface. It is the consumer end of the `debug_wb_*` trace port. A golden-trace source pushes expected register writes through a valid/ready FIFO. The checker compares every architectural register write the core reports against the FIFO head, counts matches, latches the first mismatch and reports done/pass/fail when the core reaches a terminal PC.

## Interface
Parameters:
- FIFO_DEPTH, 8: golden-entry FIFO depth; power of two, 2..64.
- END_PC, 32'h1c000100: PC whose appearance on `debug_wb_pc` ends the test.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- debug_wb_pc  in  32  core write-back PC
- debug_wb_rf_we  in  4  per-byte write enable from core
- debug_wb_rf_wnum  in  5  destination register
- debug_wb_rf_wdata  in  32  write data
- gold_valid  in  1  golden entry offered
- gold_ready  out  1  FIFO can accept (= ~full)
- gold_pc  in  32  expected PC
- gold_wnum  in  5  expected register
- gold_wdata  in  32  expected data
- done  out  1  END_PC reached, or error stop
- pass  out  1  done with no error
- fail  out  1  error latched
- err_code  out  2  0 none, 1 mismatch, 2 underflow
- err_pc  out  32  core PC of first failing event
- err_exp_wdata  out  32  golden wdata at failure (0 on underflow)
- err_got_wdata  out  32  core wdata at failure
- match_cnt  out  32  number of matched write events

## Operation
- Write event: `debug_wb_rf_we != 0` and `debug_wb_rf_wnum != 0`. Writes to r0 and `we == 0` cycles are ignored; they are neither checked nor popped.
- FIFO push: `gold_valid & gold_ready`. FIFO pop: a write event in the RUN state while the FIFO is non-empty. Push and pop may occur in the same cycle. No bypass: an entry pushed in cycle N is poppable from cycle N+1.
- Compare at a write event against the head entry. A match requires all three:
  - `pc == gold_pc`
  - `wnum == gold_wnum`
  - for each byte b with `we[b]` = 1, `wdata[8b+7:8b] == gold_wdata[8b+7:8b]`. Unenabled bytes are don't-care.
- Match: `match_cnt` increments by 1, wrapping at 2^32.
- Mismatch: `err_code` = 1 and `err_*` capture the event. The entry is popped.
- Write event with an empty FIFO: `err_code` = 2 and `err_exp_wdata` = 0. Nothing is popped.
- FSM:
  - RUN (reset state): check events.
  - RUN → FAIL on the first error.
  - RUN → DONE when `debug_wb_pc == END_PC`. If that same cycle carries a write event, it is checked first. If it errors, the transition is to FAIL instead.
  - FAIL and DONE are terminal until reset. No further checks, pops or counter changes. Pushes continue while not full.
- Outputs by state:
  - `done` = (DONE | FAIL)
  - `pass` = DONE
  - `fail` = FAIL
- Only the first error is recorded; `err_*` are frozen after it.

## Timing
- Reset values:
  - `done`, `pass`, `fail` = 0; `err_code` = 0; all `err_*` = 0; `match_cnt` = 0.
  - FIFO empty, so `gold_ready` = 1 the cycle after reset.
- All outputs are registered except `gold_ready`, which is combinational from FIFO occupancy.
- Latency: an event in cycle N updates `match_cnt`, `err_*` and the state outputs at the edge ending cycle N, so they are visible in cycle N+1.
- Full: `gold_ready` = 0. If a pop occurs in cycle N, `gold_ready` rises in N+1; there is no same-cycle pass-through. The source must hold valid/data while not ready.
- Reset mid-test: FIFO contents are discarded, the counter is cleared and the FSM returns to RUN on the next edge.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits. Full/empty are decided by comparing the MSB and the remaining bits.

## Test plan
- Matched run: push 3 entries (`1c000000`/r1/`0x10`, `1c000004`/r2/`0x20`, `1c000008`/r3/`0x30`), drive the matching events, then PC = END_PC → `match_cnt` = 3, `done` = `pass` = 1, `fail` = 0.
- Data mismatch: golden `1c000004`/r2/`0x20`, core drives `0x21` → next cycle `fail` = 1, `err_code` = 1, `err_pc` = `1c000004`, `err_exp_wdata` = `0x20`, `err_got_wdata` = `0x21`. Later events leave `match_cnt` unchanged.
- r0 and no-write filter: events with wnum = 0 (`we` = F) and with `we` = 0 (r5) → FIFO unchanged, `match_cnt` = 0, no error.
- Underflow: write event with the FIFO empty → `err_code` = 2, `err_exp_wdata` = 0, `fail` = 1.
- Backpressure: with depth 8, push 9 entries without events → `gold_ready` = 0 after 8. One matched event → `gold_ready` = 1 the next cycle. The 9th entry is accepted and later compared correctly.
- Simultaneous and reset cases:
  - A write event and PC = END_PC in the same cycle → the event is checked first; on match, `match_cnt`+1 and `pass` = 1.
  - Reset asserted after a FAIL → all outputs return to 0 and `gold_ready` = 1.
